// File: rtl/cmos_wr_pkg.sv
// Shared types for the CMOS frame writer: FSM states, bank index and the
// triple-buffer bank picker.
package cmos_wr_pkg;

    localparam int NUM_BANKS = 3;

    typedef logic [1:0] bank_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Lowest bank that is neither the published frame nor the one being read.
    function automatic bank_t pick_write_bank(input bank_t shown, input bank_t reading);
        bank_t pick;
        pick = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if ((bank_t'(i) != shown) && (bank_t'(i) != reading)) begin
                pick = bank_t'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cmos_wr_fifo.sv
// Synchronous show-ahead FIFO with occupancy output. The head word is visible
// on data_o whenever the FIFO is non-empty and reads as zero when empty.
// Pushes while full and pops while empty are ignored.
module cmos_wr_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 64,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LW-1:0]    level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_LVL);
    assign level_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; no reset so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cmos_frame_wr_ctrl.sv
// CMOS capture to memory writer: packs 4 pixels per 32-bit word, buffers them
// in a FIFO and issues bursts into one of three frame banks. Completed good
// frames are published on frame_bank; overflowed frames are dropped.
// Build option: CMOS_WR_TEST_PATTERN_EN replaces in_data with a per-frame
// pixel counter.
module cmos_frame_wr_ctrl
    import cmos_wr_pkg::*;
#(
    parameter int              H_PIX       = 1280,
    parameter int              V_LINES     = 720,
    parameter int              BURST_LEN   = 16,
    parameter int              FIFO_DEPTH  = 64,
    parameter int              ADDR_W      = 28,
    parameter logic [ADDR_W-1:0] BANK_STRIDE = 28'h0080000
) (
    input  logic              cmos_pclk,
    input  logic              rst_n,
    input  logic              in_vsync,
    input  logic              in_href,
    input  logic [7:0]        in_data,
    input  logic              capture_en,
    input  logic [1:0]        rd_bank,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_len,
    input  logic              wr_gnt,
    input  logic              wr_pop,
    output logic [31:0]       wr_data,
    output logic [1:0]        frame_bank,
    output logic              frame_done,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam int LVL_W       = $clog2(FIFO_DEPTH + 1);
    localparam int FRAME_WORDS = (H_PIX / 4) * V_LINES;
    // Word offset counter is sized for a nominal frame; oversized frames
    // wrap inside their own bank rather than spilling into the next one.
    localparam int WCNT_W      = $clog2(FRAME_WORDS + 1);
    localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);

    state_t             state_q, state_d;
    logic               vsync_q;
    logic               vsync_rise, vsync_fall;
    logic               pix_valid, pix_take;
    logic [7:0]         pix;
    logic [23:0]        pack_q;
    logic [1:0]         idx_q;
    logic               push_word, push_pad, fifo_push, drop;
    logic [31:0]        fifo_din;
    logic               fifo_empty, fifo_full, pop_ok;
    logic [LVL_W-1:0]   fifo_level;
    logic               start_frame;
    bank_t              wbank_q, frame_bank_q;
    logic               bad_q, frame_done_q, overflow_q;
    logic [7:0]         drop_cnt_q;
    logic               req_q, burst_q, want_req;
    logic [7:0]         len_q, rem_q;
    logic [WCNT_W-1:0]  wcnt_q;
    logic [ADDR_W-1:0]  bank_base;

    assign vsync_rise  = in_vsync && !vsync_q;
    assign vsync_fall  = !in_vsync && vsync_q;
    assign pix_valid   = in_vsync && in_href;
    assign pix_take    = pix_valid && (state_q == CAPTURE);
    assign start_frame = (state_q == ARM) && vsync_rise;

    // Frame-valid history for edge detection.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) vsync_q <= 1'b0;
        else        vsync_q <= in_vsync;
    end

`ifdef CMOS_WR_TEST_PATTERN_EN
    logic [7:0] pat_q;
    logic       unused_in_data;
    assign unused_in_data = ^in_data;
    assign pix            = pat_q;

    // Test pattern: restart at each frame start, advance per valid pixel.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n)          pat_q <= '0;
        else if (vsync_rise) pat_q <= '0;
        else if (pix_valid)  pat_q <= pat_q + 8'd1;
    end
`else
    assign pix = in_data;
`endif

    // A word is complete on the 4th pixel; a partial word is flushed,
    // zero-padded, when the frame ends.
    assign push_word = pix_take && (idx_q == 2'd3);
    assign push_pad  = (state_q == CAPTURE) && vsync_fall && (idx_q != 2'd0);
    assign fifo_push = push_word || push_pad;
    assign fifo_din  = push_word ? {pix, pack_q} : {8'h00, pack_q};
    assign drop      = fifo_push && fifo_full;

    // Pixel packer, first pixel in the low byte.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            idx_q  <= '0;
        end else if (start_frame || push_pad) begin
            pack_q <= '0;
            idx_q  <= '0;
        end else if (pix_take) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    pack_q[7:0]   <= pix;
                2'd1:    pack_q[15:8]  <= pix;
                2'd2:    pack_q[23:16] <= pix;
                default: pack_q        <= '0;
            endcase
        end
    end

    assign pop_ok = wr_pop && !fifo_empty;

    cmos_wr_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (cmos_pclk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .data_i  (fifo_din),
        .pop_i   (wr_pop),
        .data_o  (wr_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    // FSM state register.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture_en) state_d = ARM;
            ARM:     if (vsync_rise) state_d = CAPTURE;
            CAPTURE: if (vsync_fall) state_d = FLUSH;
            FLUSH:   if (fifo_empty && !burst_q && !req_q) state_d = DONE;
            DONE:    state_d = capture_en ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-frame bank choice, frame health and publication.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_q      <= '0;
            bad_q        <= 1'b0;
            frame_bank_q <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (start_frame) begin
                wbank_q <= pick_write_bank(frame_bank_q, rd_bank);
                bad_q   <= 1'b0;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                bad_q      <= 1'b1;
            end
            if (state_q == DONE) begin
                if (!bad_q) begin
                    frame_bank_q <= wbank_q;
                    frame_done_q <= 1'b1;
                end else if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end
        end
    end

    // One burst in flight at a time: request, grant, then wr_len pops.
    assign want_req = !req_q && !burst_q &&
                      (((state_q == CAPTURE) && (fifo_level >= BURST_LVL)) ||
                       ((state_q == FLUSH) && (fifo_level != '0)));

    // Burst request / tracking and issued-word offset.
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            burst_q <= 1'b0;
            len_q   <= '0;
            rem_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            if (start_frame) wcnt_q <= '0;
            if (want_req) begin
                req_q <= 1'b1;
                len_q <= (fifo_level >= BURST_LVL) ? 8'(BURST_LEN) : 8'(fifo_level);
            end else if (req_q && wr_gnt) begin
                req_q   <= 1'b0;
                burst_q <= 1'b1;
                rem_q   <= len_q;
                wcnt_q  <= wcnt_q + WCNT_W'(len_q);
            end else if (burst_q && pop_ok) begin
                rem_q <= rem_q - 8'd1;
                if (rem_q == 8'd1) burst_q <= 1'b0;
            end
        end
    end

    assign bank_base  = BANK_STRIDE * ADDR_W'(wbank_q);
    assign wr_addr    = bank_base + ADDR_W'(wcnt_q);
    assign wr_req     = req_q;
    assign wr_len     = len_q;
    assign frame_bank = frame_bank_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_cmos_frame_wr_ctrl.sv
// Directed bench for cmos_frame_wr_ctrl: 4-pixel lines, 16-word bursts,
// 32-word FIFO. Works with or without CMOS_WR_TEST_PATTERN_EN.
module tb_cmos_frame_wr_ctrl;
    import cmos_wr_pkg::*;

    localparam logic [27:0] STRIDE = 28'h0080000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vsync, in_href, capture_en, wr_gnt, wr_pop;
    logic [7:0]  in_data;
    logic [1:0]  rd_bank;
    logic        wr_req, frame_done, overflow;
    logic [27:0] wr_addr;
    logic [7:0]  wr_len, drop_cnt;
    logic [31:0] wr_data;
    logic [1:0]  frame_bank;

    int          n_checks = 0;
    int          n_pass = 0;
    int          done_pulses = 0;
    logic [31:0] exp_words[$];

    always #5 clk = ~clk;

    cmos_frame_wr_ctrl #(
        .H_PIX       (4),
        .V_LINES     (16),
        .BURST_LEN   (16),
        .FIFO_DEPTH  (32),
        .ADDR_W      (28),
        .BANK_STRIDE (STRIDE)
    ) dut (
        .cmos_pclk  (clk),
        .rst_n      (rst_n),
        .in_vsync   (in_vsync),
        .in_href    (in_href),
        .in_data    (in_data),
        .capture_en (capture_en),
        .rd_bank    (rd_bank),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_len     (wr_len),
        .wr_gnt     (wr_gnt),
        .wr_pop     (wr_pop),
        .wr_data    (wr_data),
        .frame_bank (frame_bank),
        .frame_done (frame_done),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always @(posedge clk) if (frame_done === 1'b1) done_pulses++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [7:0] exp_pix(input int base, input int i);
        int eff;
        eff = base;
`ifdef CMOS_WR_TEST_PATTERN_EN
        eff = 0;
`endif
        return 8'(eff + i);
    endfunction

    task automatic expect_frame(input int base, input int npix);
        logic [31:0] w;
        for (int k = 0; k * 4 < npix; k++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                if (k * 4 + j < npix) w[8*j +: 8] = exp_pix(base, k * 4 + j);
            exp_words.push_back(w);
        end
    endtask

    // Full lines of 4 pixels; last line carries last_len pixels.
    task automatic send_frame(input int lines, input int last_len, input int base, input int en_off_line);
        int i;
        i = 0;
        in_vsync = 1'b1;
        tick(2);
        for (int l = 0; l < lines; l++) begin
            if (l == en_off_line) capture_en = 1'b0;
            for (int p = 0; p < ((l == lines - 1) ? last_len : 4); p++) begin
                in_href = 1'b1;
                in_data = 8'(base + i);
                i++;
                tick(1);
            end
            in_href = 1'b0;
            tick(2);
        end
        in_vsync = 1'b0;
        tick(2);
    endtask

    task automatic wait_req(input string tag);
        for (int c = 0; c < 200 && wr_req !== 1'b1; c++) tick(1);
        chk({tag, "_req"}, 32'(wr_req), 32'd1);
    endtask

    task automatic serve_burst(input string tag, input logic [27:0] addr, input int len, input int npops);
        wait_req(tag);
        chk({tag, "_addr"}, 32'(wr_addr), 32'(addr));
        chk({tag, "_len"}, 32'(wr_len), 32'(len));
        wr_gnt = 1'b1;
        tick(1);
        wr_gnt = 1'b0;
        chk({tag, "_req_drop"}, 32'(wr_req), 32'd0);
        wr_pop = 1'b1;
        for (int k = 0; k < npops; k++) begin
            chk($sformatf("%s_w%0d", tag, k), wr_data, exp_words.pop_front());
            tick(1);
        end
        wr_pop = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 30 && frame_done !== 1'b1; c++) tick(1);
        chk({tag, "_done"}, 32'(frame_done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_vsync = 1'b0; in_href = 1'b0; in_data = '0;
        capture_en = 1'b0; rd_bank = 2'd0; wr_gnt = 1'b0; wr_pop = 1'b0;
        tick(3);
        chk("rst_req", 32'(wr_req), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_len", 32'(wr_len), 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_bank", 32'(frame_bank), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        capture_en = 1'b1;
        tick(2);

        // Frame 1: 4x4, pixels 0..15, fb=0 rb=0 -> bank 1, single FLUSH burst
        expect_frame(0, 16);
        send_frame(4, 4, 0, -1);
        serve_burst("f1", STRIDE, 4, 4);
        wait_done("f1");
        chk("f1_bank", 32'(frame_bank), 32'd1);
        tick(1);
        chk("f1_pulse_end", 32'(frame_done), 32'd0);
        $display("frame1 bank=%0d pulses=%0d", frame_bank, done_pulses);

        // Frame 2: fb=1 rb=0 -> bank 2
        expect_frame(16, 16);
        send_frame(4, 4, 16, -1);
        serve_burst("f2", 28'(2 * STRIDE), 4, 4);
        wait_done("f2");
        chk("f2_bank", 32'(frame_bank), 32'd2);
        $display("frame2 bank=%0d pulses=%0d", frame_bank, done_pulses);

        // Frame 3: 40 words with grant withheld -> overflow, bank 1 drained, not published
        expect_frame(0, 128);
        send_frame(40, 4, 0, -1);
        chk("f3_ovf", 32'(overflow), 32'd1);
        serve_burst("f3a", STRIDE, 16, 16);
        serve_burst("f3b", STRIDE + 28'd16, 16, 16);
        tick(10);
        chk("f3_drop", 32'(drop_cnt), 32'd1);
        chk("f3_bank", 32'(frame_bank), 32'd2);
        chk("f3_pulses", 32'(done_pulses), 32'd2);
        $display("frame3 overflow=%0d drop_cnt=%0d", overflow, drop_cnt);

        // Frame 4 then a vsync rise while FLUSH is held waiting on grant
        expect_frame(32, 16);
        send_frame(4, 4, 32, -1);
        wait_req("f4_hold");
        send_frame(4, 4, 64, -1);
        serve_burst("f4", STRIDE, 4, 4);
        wait_done("f4");
        chk("f4_bank", 32'(frame_bank), 32'd1);
        tick(3);
        chk("f4_pulses", 32'(done_pulses), 32'd3);
        $display("frame4 bank=%0d pulses=%0d", frame_bank, done_pulses);

        // Frame 5: captured normally after the skipped frame, fb=1 -> bank 2
        expect_frame(48, 16);
        send_frame(4, 4, 48, -1);
        serve_burst("f5", 28'(2 * STRIDE), 4, 4);
        wait_done("f5");
        chk("f5_bank", 32'(frame_bank), 32'd2);
        chk("f5_drop", 32'(drop_cnt), 32'd1);
        $display("frame5 bank=%0d drop_cnt=%0d", frame_bank, drop_cnt);

        // Frame 6: reset in the middle of the burst
        expect_frame(0, 16);
        send_frame(4, 4, 0, -1);
        serve_burst("f6", STRIDE, 4, 2);
        rst_n = 1'b0;
        #1;
        chk("f6_rst_data", wr_data, 32'd0);
        chk("f6_rst_bank", 32'(frame_bank), 32'd0);
        chk("f6_rst_ovf", 32'(overflow), 32'd0);
        chk("f6_rst_drop", 32'(drop_cnt), 32'd0);
        chk("f6_rst_state", 32'(dut.state_q), 32'(IDLE));
        exp_words.delete();
        capture_en = 1'b0;
        tick(1);
        chk("f6_rst_req", 32'(wr_req), 32'd0);
        rst_n = 1'b1;
        tick(1);
        // stray grant and pop with nothing outstanding
        wr_gnt = 1'b1; wr_pop = 1'b1;
        tick(1);
        wr_gnt = 1'b0; wr_pop = 1'b0;
        tick(5);
        chk("f6_idle_req", 32'(wr_req), 32'd0);
        chk("f6_idle_state", 32'(dut.state_q), 32'(IDLE));
        $display("frame6 reset: bank=%0d req=%0d", frame_bank, wr_req);

        // Frame 7: 14 pixels (padded last word), fb=0 rb=1 -> bank 2, capture_en dropped mid-frame
        rd_bank = 2'd1;
        capture_en = 1'b1;
        tick(2);
        expect_frame(0, 14);
        send_frame(4, 2, 0, 1);
        serve_burst("f7", 28'(2 * STRIDE), 4, 4);
        wait_done("f7");
        chk("f7_bank", 32'(frame_bank), 32'd2);
        tick(3);
        chk("f7_state", 32'(dut.state_q), 32'(IDLE));
        chk("f7_pulses", 32'(done_pulses), 32'd5);
        $display("frame7 bank=%0d pulses=%0d", frame_bank, done_pulses);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
